mc_controller: RTL and testbench

Multicycle control FSM for the 32-bit RISC core. It sequences the shared ALU, the unified instruction/data memory and the register file through fetch, decode, execute, memory and writeback steps. It generates all datapath enables and the 3-bit ALU control, which it decodes internally from aluop and funct. It waits on a memory ready handshake and enters a sticky trap on an illegal opcode or funct.

---
 rtl/mc_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_mc_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for the 32-bit RISC core.
//
// Sequences the shared ALU, the unified instruction/data memory and the
// register file through fetch / decode / execute / memory / writeback.
// Illegal opcodes or R-type functs park the FSM in a sticky TRAP state
// that only reset leaves.
//
// Handshake: the memory side owns mem_ready. A memory access (FETCH,
// MEMRD, MEMWR) holds its request every cycle and completes in the cycle
// mem_ready is sampled high. The FSM advances on that same edge.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   op, funct           opcode / funct fields from the instruction register
//   zero                ALU zero flag (beq decision)
//   mem_ready           memory completes the current access this cycle
//   pcwrite .. pcsrc    datapath enables and mux selects (Moore-decoded)
//   alucontrol          3-bit ALU operation decoded from aluop and funct
//   retire              one-cycle pulse when an instruction completes
//   trap                sticky illegal-instruction flag (registered)
//   state               current state encoding (debug)
module mc_controller #(
    parameter int OPW = 4,
    parameter int FW  = 4,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic [FW-1:0]  funct,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pcwrite,
    output logic           irwrite,
    output logic           iord,
    output logic           memread,
    output logic           memwrite,
    output logic           regwrite,
    output logic           regdst,
    output logic           memtoreg,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic           pcsrc,
    output logic [2:0]     alucontrol,
    output logic           retire,
    output logic           trap,
    output logic [STW-1:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        IMMEX   = 4'd8,
        BEQEX   = 4'd9,
        TRAP    = 4'd10
    } state_t;

    localparam logic [OPW-1:0] OP_R    = OPW'(0);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
    localparam logic [OPW-1:0] OP_SLTI = OPW'(2);
    localparam logic [OPW-1:0] OP_LW   = OPW'(3);
    localparam logic [OPW-1:0] OP_SW   = OPW'(4);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(5);

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_SLT   = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b11;

    state_t     cur;
    state_t     nxt;
    logic       trap_r;
    logic [1:0] aluop;
    logic       funct_ok;
    // Raw Moore enables before reset gating.
    logic       pcwrite_s, irwrite_s, memwrite_s, regwrite_s, retire_s;

    // funct decode: only 0..4 are legal R-type functions.
    always_comb begin
        funct_ok   = 1'b1;
        alucontrol = 3'b000;
        case (aluop)
            ALUOP_ADD: alucontrol = 3'b000;
            ALUOP_SUB: alucontrol = 3'b001;
            ALUOP_SLT: alucontrol = 3'b100;
            default: begin
                case (funct)
                    FW'(0):  alucontrol = 3'b000;
                    FW'(1):  alucontrol = 3'b001;
                    FW'(2):  alucontrol = 3'b010;
                    FW'(3):  alucontrol = 3'b011;
                    FW'(4):  alucontrol = 3'b100;
                    default: begin
                        alucontrol = 3'b000;
                        funct_ok   = 1'b0;
                    end
                endcase
            end
        endcase
        // Legality must not depend on the current aluop, so recheck funct.
        funct_ok = (funct <= FW'(4));
    end

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_R:             nxt = funct_ok ? RTYPEEX : TRAP;
                    OP_ADDI, OP_SLTI: nxt = IMMEX;
                    OP_LW, OP_SW:     nxt = MEMADR;
                    OP_BEQ:           nxt = BEQEX;
                    default:          nxt = TRAP;
                endcase
            end
            MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
            MEMWB:   nxt = FETCH;
            MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
            RTYPEEX: nxt = ALUWB;
            IMMEX:   nxt = ALUWB;
            ALUWB:   nxt = FETCH;
            BEQEX:   nxt = FETCH;
            TRAP:    nxt = TRAP;
            default: nxt = FETCH;   // unused encodings recover to FETCH
        endcase
    end

    // trap is registered alongside state so it is high exactly while in TRAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur    <= FETCH;
            trap_r <= 1'b0;
        end else begin
            cur    <= nxt;
            trap_r <= (nxt == TRAP);
        end
    end

    always_comb begin
        pcwrite_s  = 1'b0;
        irwrite_s  = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 1'b0;
        retire_s   = 1'b0;
        aluop      = ALUOP_ADD;
        case (cur)
            FETCH: begin
                memread   = 1'b1;
                alusrcb   = 2'b01;
                irwrite_s = mem_ready;
                pcwrite_s = mem_ready;
            end
            DECODE:  alusrcb = 2'b10;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg   = 1'b1;
                retire_s   = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
                retire_s   = mem_ready;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = (op == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            ALUWB: begin
                regwrite_s = 1'b1;
                regdst     = (op == OP_R);
                retire_s   = 1'b1;
            end
            BEQEX: begin
                alusrca   = 1'b1;
                aluop     = ALUOP_SUB;
                pcsrc     = 1'b1;
                pcwrite_s = zero;
                retire_s  = 1'b1;
            end
            default: ;
        endcase
    end

    // While reset is held no architectural write or retire may escape.
    assign pcwrite  = pcwrite_s  & ~reset;
    assign irwrite  = irwrite_s  & ~reset;
    assign memwrite = memwrite_s & ~reset;
    assign regwrite = regwrite_s & ~reset;
    assign retire   = retire_s   & ~reset;
    assign trap     = trap_r;
    assign state    = STW'(cur);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: a per-cycle vector table of
// {reset, op, funct, zero, mem_ready} -> {state, packed control word},
// followed by a hand-written sw sequence with a random memory wait.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] op = 4'd0;
    logic [3:0] funct = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pcwrite, irwrite, iord, memread, memwrite, regwrite, regdst;
    logic       memtoreg, alusrca, pcsrc, retire, trap;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] state;

    mc_controller #(.OPW(4), .FW(4), .STW(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcwrite(pcwrite), .irwrite(irwrite),
        .iord(iord), .memread(memread), .memwrite(memwrite),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .retire(retire), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    // Control word layout:
    // [16] pcwrite [15] irwrite [14] iord [13] memread [12] memwrite
    // [11] regwrite [10] regdst [9] memtoreg [8] alusrca [7:6] alusrcb
    // [5] pcsrc [4:2] alucontrol [1] retire [0] trap
    localparam logic [16:0] PCW  = 17'h10000;
    localparam logic [16:0] IRW  = 17'h08000;
    localparam logic [16:0] IORD = 17'h04000;
    localparam logic [16:0] MRD  = 17'h02000;
    localparam logic [16:0] MWR  = 17'h01000;
    localparam logic [16:0] RW   = 17'h00800;
    localparam logic [16:0] RDST = 17'h00400;
    localparam logic [16:0] M2R  = 17'h00200;
    localparam logic [16:0] SA   = 17'h00100;
    localparam logic [16:0] SB4  = 17'h00040;
    localparam logic [16:0] SBI  = 17'h00080;
    localparam logic [16:0] PSRC = 17'h00020;
    localparam logic [16:0] SUB  = 17'h00004;
    localparam logic [16:0] AND_ = 17'h00008;
    localparam logic [16:0] OR_  = 17'h0000C;
    localparam logic [16:0] SLT  = 17'h00010;
    localparam logic [16:0] RET  = 17'h00002;
    localparam logic [16:0] TRP  = 17'h00001;

    localparam logic [16:0] F_WAIT = MRD | SB4;
    localparam logic [16:0] F_GO   = MRD | SB4 | PCW | IRW;
    localparam logic [16:0] ENABLES = PCW | IRW | MWR | RW | RET;

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic [3:0]  funct;
        logic        zero;
        logic        mr;
        logic [3:0]  exp_state;
        logic [16:0] exp_ctl;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic add(input logic rst, input logic [3:0] o, input logic [3:0] f,
                       input logic z, input logic mr, input logic [3:0] st,
                       input logic [16:0] ctl, input string nm);
        vec_t v;
        v.rst = rst; v.op = o; v.funct = f; v.zero = z; v.mr = mr;
        v.exp_state = st; v.exp_ctl = ctl; v.name = nm;
        vecs.push_back(v);
    endtask

    function automatic logic [16:0] ctl_now();
        return {pcwrite, irwrite, iord, memread, memwrite, regwrite, regdst,
                memtoreg, alusrca, alusrcb, pcsrc, alucontrol, retire, trap};
    endfunction

    task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    int wait_n, k, mw_cnt, rt_cnt;
    bit done;

    initial begin
        // reset held for 2 cycles: FETCH, trap clear, no write enables
        add(1, 4'd3, 0, 0, 1, 0, F_WAIT, "reset0");
        add(1, 4'd3, 0, 0, 1, 0, F_WAIT, "reset1");
        // lw, 5 cycles
        add(0, 4'd3, 0, 0, 1, 0, F_GO, "lw_fetch");
        add(0, 4'd3, 0, 0, 1, 1, SBI, "lw_decode");
        add(0, 4'd3, 0, 0, 1, 2, SA | SBI, "lw_memadr");
        add(0, 4'd3, 0, 0, 1, 3, IORD | MRD, "lw_memrd");
        add(0, 4'd3, 0, 0, 1, 4, RW | M2R | RET, "lw_memwb");
        // R-type sub, 4 cycles
        add(0, 4'd0, 4'd1, 0, 1, 0, F_GO, "sub_fetch");
        add(0, 4'd0, 4'd1, 0, 1, 1, SBI, "sub_decode");
        add(0, 4'd0, 4'd1, 0, 1, 6, SA | SUB, "sub_ex");
        add(0, 4'd0, 4'd1, 0, 1, 7, RW | RDST | RET, "sub_wb");
        // R-type or
        add(0, 4'd0, 4'd3, 0, 1, 0, F_GO, "or_fetch");
        add(0, 4'd0, 4'd3, 0, 1, 1, SBI, "or_decode");
        add(0, 4'd0, 4'd3, 0, 1, 6, SA | OR_, "or_ex");
        add(0, 4'd0, 4'd3, 0, 1, 7, RW | RDST | RET, "or_wb");
        // R-type and, slt
        add(0, 4'd0, 4'd2, 0, 1, 0, F_GO, "and_fetch");
        add(0, 4'd0, 4'd2, 0, 1, 1, SBI, "and_decode");
        add(0, 4'd0, 4'd2, 0, 1, 6, SA | AND_, "and_ex");
        add(0, 4'd0, 4'd2, 0, 1, 7, RW | RDST | RET, "and_wb");
        add(0, 4'd0, 4'd4, 0, 1, 0, F_GO, "rslt_fetch");
        add(0, 4'd0, 4'd4, 0, 1, 1, SBI, "rslt_decode");
        add(0, 4'd0, 4'd4, 0, 1, 6, SA | SLT, "rslt_ex");
        add(0, 4'd0, 4'd4, 0, 1, 7, RW | RDST | RET, "rslt_wb");
        // beq taken, then not taken
        add(0, 4'd5, 0, 1, 1, 0, F_GO, "beq1_fetch");
        add(0, 4'd5, 0, 1, 1, 1, SBI, "beq1_decode");
        add(0, 4'd5, 0, 1, 1, 9, SA | SUB | PSRC | RET | PCW, "beq1_ex");
        add(0, 4'd5, 0, 0, 1, 0, F_GO, "beq0_fetch");
        add(0, 4'd5, 0, 0, 1, 1, SBI, "beq0_decode");
        add(0, 4'd5, 0, 0, 1, 9, SA | SUB | PSRC | RET, "beq0_ex");
        // sw: FETCH waits 2 cycles, MEMWR waits 3 cycles
        add(0, 4'd4, 0, 0, 0, 0, F_WAIT, "sw_fwait0");
        add(0, 4'd4, 0, 0, 0, 0, F_WAIT, "sw_fwait1");
        add(0, 4'd4, 0, 0, 1, 0, F_GO, "sw_fetch");
        add(0, 4'd4, 0, 0, 1, 1, SBI, "sw_decode");
        add(0, 4'd4, 0, 0, 1, 2, SA | SBI, "sw_memadr");
        add(0, 4'd4, 0, 0, 0, 5, IORD | MWR, "sw_wait0");
        add(0, 4'd4, 0, 0, 0, 5, IORD | MWR, "sw_wait1");
        add(0, 4'd4, 0, 0, 0, 5, IORD | MWR, "sw_wait2");
        add(0, 4'd4, 0, 0, 1, 5, IORD | MWR | RET, "sw_done");
        // slti and addi
        add(0, 4'd2, 0, 0, 1, 0, F_GO, "slti_fetch");
        add(0, 4'd2, 0, 0, 1, 1, SBI, "slti_decode");
        add(0, 4'd2, 0, 0, 1, 8, SA | SBI | SLT, "slti_ex");
        add(0, 4'd2, 0, 0, 1, 7, RW | RET, "slti_wb");
        add(0, 4'd1, 0, 0, 1, 0, F_GO, "addi_fetch");
        add(0, 4'd1, 0, 0, 1, 1, SBI, "addi_decode");
        add(0, 4'd1, 0, 0, 1, 8, SA | SBI, "addi_ex");
        add(0, 4'd1, 0, 0, 1, 7, RW | RET, "addi_wb");
        // illegal opcode -> sticky trap, then reset
        add(0, 4'd15, 0, 0, 1, 0, F_GO, "ill_fetch");
        add(0, 4'd15, 0, 0, 1, 1, SBI, "ill_decode");
        for (int i = 0; i < 11; i++) add(0, 4'd15, 0, 1, 1, 10, TRP, "ill_trap");
        add(1, 4'd15, 0, 0, 1, 10, TRP, "ill_reset");
        add(0, 4'd0, 4'd7, 0, 0, 0, F_WAIT, "ill_after");
        // illegal funct -> trap, then reset
        add(0, 4'd0, 4'd7, 0, 1, 0, F_GO, "illf_fetch");
        add(0, 4'd0, 4'd7, 0, 1, 1, SBI, "illf_decode");
        for (int i = 0; i < 4; i++) add(0, 4'd0, 4'd7, 0, 1, 10, TRP, "illf_trap");
        add(1, 4'd0, 4'd7, 0, 1, 10, TRP, "illf_reset");
        add(0, 4'd3, 0, 0, 0, 0, F_WAIT, "illf_after");
        // reset while MEMRD waits on memory: abandoned, no regwrite/retire
        add(0, 4'd3, 0, 0, 1, 0, F_GO, "rst_fetch");
        add(0, 4'd3, 0, 0, 1, 1, SBI, "rst_decode");
        add(0, 4'd3, 0, 0, 1, 2, SA | SBI, "rst_memadr");
        add(0, 4'd3, 0, 0, 0, 3, IORD | MRD, "rst_memrd");
        add(1, 4'd3, 0, 0, 0, 3, IORD | MRD, "rst_assert");
        add(0, 4'd3, 0, 0, 0, 0, F_WAIT, "rst_after");

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset     = vecs[i].rst;
            op        = vecs[i].op;
            funct     = vecs[i].funct;
            zero      = vecs[i].zero;
            mem_ready = vecs[i].mr;
            #3;
            check({vecs[i].name, "_state"}, {13'd0, state}, {13'd0, vecs[i].exp_state});
            check({vecs[i].name, "_ctl"}, ctl_now(), vecs[i].exp_ctl);
        end

        // sw with a random memory wait: memwrite held wait_n+1 cycles,
        // exactly one retire, and the FSM returns to FETCH.
        wait_n = $urandom_range(1, 5);
        k = 0; mw_cnt = 0; rt_cnt = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clk);
            #1;
            reset = 0; op = 4'd4; funct = 0; zero = 0;
            if (state == 4'd5) begin
                mem_ready = (k == wait_n);
                k++;
            end else begin
                mem_ready = 1'b1;
            end
            #3;
            if ((ctl_now() & ENABLES & ~(PCW | IRW)) != 0 && state != 4'd5) mw_cnt += 100;
            mw_cnt += int'(memwrite);
            rt_cnt += int'(retire);
            if (c > 0 && state == 4'd0) done = 1;
        end
        check("rsw_done", {16'd0, done}, 17'd1);
        check("rsw_memwrite_cycles", 17'(mw_cnt), 17'(wait_n + 1));
        check("rsw_retire_count", 17'(rt_cnt), 17'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
